// File: rtl/raster_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : raster_pixel_writer
//  Description : Buffers rasterizer pixels, runs a 2-bit depth test against
//                an external depth buffer, writes passing pixels to the
//                framebuffer, clears the depth buffer on request and signals
//                frame completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_pixel_writer #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 19
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_sig_start_new_triangle,
    input  logic              in_sig_clear_depth,
    input  logic              in_sig_write_pixel,
    input  logic              in_sig_rasterize_done,
    input  logic [15:0]       in_pixel_x,
    input  logic [15:0]       in_pixel_y,
    input  logic [1:0]        in_pixel_depth,
    input  logic [15:0]       in_pixel_color,
    output logic [ADDR_W-1:0] out_zb_addr,
    output logic [1:0]        out_zb_wdata,
    output logic              out_zb_we,
    input  logic [1:0]        in_zb_rdata,
    output logic [ADDR_W-1:0] out_fb_addr,
    output logic [15:0]       out_fb_data,
    output logic              out_fb_we,
    input  logic              in_fb_ready,
    output logic              out_sig_fifo_full,
    output logic              out_sig_busy,
    output logic              out_sig_overflow,
    output logic              out_sig_frame_done,
    output logic [19:0]       out_pixels_written,
    output logic [19:0]       out_pixels_rejected
);

    localparam int                c_ptr_w    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                c_entry_w  = ADDR_W + 18;
    localparam logic [15:0]       c_screen_w = 16'(SCREEN_W);
    localparam logic [15:0]       c_screen_h = 16'(SCREEN_H);
    localparam logic [ADDR_W-1:0] c_clr_last = ADDR_W'(SCREEN_W * SCREEN_H - 1);
    localparam logic [c_ptr_w:0]  c_fifo_cap = (c_ptr_w + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ_Z   = 3'd1,
        ST_TEST     = 3'd2,
        ST_WRITE_FB = 3'd3,
        ST_CLEAR    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [c_entry_w-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]      count_q, count_d;
    logic [ADDR_W-1:0]     work_addr_q, work_addr_d;
    logic [1:0]            work_depth_q, work_depth_d;
    logic [15:0]           work_color_q, work_color_d;
    logic [ADDR_W-1:0]     clr_addr_q, clr_addr_d;
    logic                  clear_pend_q, clear_pend_d;
    logic                  done_seen_q, done_seen_d;
    logic                  raster_done_prev_q, raster_done_prev_d;
    logic                  overflow_q, overflow_d;
    logic [19:0]           written_q, written_d;
    logic [19:0]           rejected_q, rejected_d;

    logic                  w_on_screen, w_strobe_ok, w_fifo_empty, w_fifo_full;
    logic                  w_pop, w_push, w_drop, w_enter_clear, w_depth_pass;
    logic                  w_fire_done, w_fb_accept, w_test_fail;
    logic [ADDR_W-1:0]     w_pix_addr;
    logic [c_entry_w-1:0]  w_push_entry, w_head_entry;
    logic [1:0]            w_rej_inc;
    logic [20:0]           w_rej_sum;

    assign w_on_screen   = (in_pixel_x < c_screen_w) && (in_pixel_y < c_screen_h);
    assign w_strobe_ok   = in_sig_write_pixel && w_on_screen;
    assign w_fifo_empty  = (count_q == '0);
    assign w_fifo_full   = (count_q == c_fifo_cap);
    assign w_pop         = (state_q == ST_IDLE) && !w_fifo_empty;
    // A full FIFO still accepts a pixel when the head leaves in the same cycle
    assign w_push        = w_strobe_ok && (!w_fifo_full || w_pop);
    assign w_drop        = w_strobe_ok && w_fifo_full && !w_pop;
    assign w_enter_clear = (state_q == ST_IDLE) && clear_pend_q && w_fifo_empty;
    assign w_depth_pass  = (work_depth_q <= in_zb_rdata);
    assign w_fb_accept   = (state_q == ST_WRITE_FB) && in_fb_ready;
    assign w_test_fail   = (state_q == ST_TEST) && !w_depth_pass;
    assign w_fire_done   = done_seen_q && (state_q == ST_IDLE) && w_fifo_empty && !clear_pend_q;
    assign w_pix_addr    = ADDR_W'(in_pixel_y) * ADDR_W'(SCREEN_W) + ADDR_W'(in_pixel_x);
    assign w_push_entry  = {w_pix_addr, in_pixel_depth, in_pixel_color};
    assign w_head_entry  = fifo_mem_q[rd_ptr_q];
    // Off-screen strobe and a failed depth test can land in the same cycle
    assign w_rej_inc     = {1'b0, in_sig_write_pixel && !w_on_screen} + {1'b0, w_test_fail};
    assign w_rej_sum     = {1'b0, rejected_q} + {19'd0, w_rej_inc};

    // FIFO bookkeeping, status flags and saturating counters
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + (c_ptr_w + 1)'(1);
            2'b01:   count_d = count_q - (c_ptr_w + 1)'(1);
            default: count_d = count_q;
        endcase

        overflow_d         = (overflow_q && !in_sig_start_new_triangle) || w_drop;
        raster_done_prev_d = in_sig_rasterize_done;

        done_seen_d = done_seen_q;
        if (w_fire_done) done_seen_d = 1'b0;
        if (in_sig_rasterize_done && !raster_done_prev_q) done_seen_d = 1'b1;
        if (in_sig_start_new_triangle) done_seen_d = 1'b0;

        clear_pend_d = clear_pend_q;
        if (w_enter_clear) clear_pend_d = 1'b0;
        if (in_sig_clear_depth) clear_pend_d = 1'b1;

        written_d = written_q;
        if (w_fb_accept && (written_q != '1)) written_d = written_q + 20'd1;
        rejected_d = w_rej_sum[20] ? '1 : w_rej_sum[19:0];
        if (w_enter_clear) begin
            written_d  = '0;
            rejected_d = '0;
        end
    end

    // Pixel-processing state machine and working registers
    always_comb begin
        state_d      = state_q;
        work_addr_d  = work_addr_q;
        work_depth_d = work_depth_q;
        work_color_d = work_color_q;
        clr_addr_d   = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (w_enter_clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (w_pop) begin
                    {work_addr_d, work_depth_d, work_color_d} = w_head_entry;
                    state_d = ST_READ_Z;
                end
            end
            ST_READ_Z:   state_d = ST_TEST;
            ST_TEST:     state_d = w_depth_pass ? ST_WRITE_FB : ST_IDLE;
            ST_WRITE_FB: if (in_fb_ready) state_d = ST_IDLE;
            ST_CLEAR: begin
                if (clr_addr_q == c_clr_last) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q            <= ST_IDLE;
            wr_ptr_q           <= '0;
            rd_ptr_q           <= '0;
            count_q            <= '0;
            work_addr_q        <= '0;
            work_depth_q       <= '0;
            work_color_q       <= '0;
            clr_addr_q         <= '0;
            clear_pend_q       <= 1'b0;
            done_seen_q        <= 1'b0;
            raster_done_prev_q <= 1'b0;
            overflow_q         <= 1'b0;
            written_q          <= '0;
            rejected_q         <= '0;
        end else begin
            state_q            <= state_d;
            wr_ptr_q           <= wr_ptr_d;
            rd_ptr_q           <= rd_ptr_d;
            count_q            <= count_d;
            work_addr_q        <= work_addr_d;
            work_depth_q       <= work_depth_d;
            work_color_q       <= work_color_d;
            clr_addr_q         <= clr_addr_d;
            clear_pend_q       <= clear_pend_d;
            done_seen_q        <= done_seen_d;
            raster_done_prev_q <= raster_done_prev_d;
            overflow_q         <= overflow_d;
            written_q          <= written_d;
            rejected_q         <= rejected_d;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy count is zero
    always_ff @(posedge clock) begin
        if (w_push) fifo_mem_q[wr_ptr_q] <= w_push_entry;
    end

    assign out_zb_we           = (state_q == ST_CLEAR) || ((state_q == ST_TEST) && w_depth_pass);
    assign out_zb_wdata        = (state_q == ST_CLEAR) ? 2'b11 :
                                 (((state_q == ST_TEST) && w_depth_pass) ? work_depth_q : 2'b00);
    assign out_zb_addr         = (state_q == ST_CLEAR) ? clr_addr_q : work_addr_q;
    assign out_fb_we           = (state_q == ST_WRITE_FB);
    assign out_fb_addr         = work_addr_q;
    assign out_fb_data         = work_color_q;
    assign out_sig_fifo_full   = w_fifo_full;
    assign out_sig_busy        = (state_q != ST_IDLE) || !w_fifo_empty;
    assign out_sig_overflow    = overflow_q;
    assign out_sig_frame_done  = w_fire_done;
    assign out_pixels_written  = written_q;
    assign out_pixels_rejected = rejected_q;

endmodule
`default_nettype wire

// File: tb/tb_raster_pixel_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_raster_pixel_writer
//  Description : Directed self-checking bench for raster_pixel_writer on an
//                8x4 screen with a 4-entry FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_raster_pixel_writer;

    localparam int ADDR_W = 19;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              start_tri, clear_depth, write_pixel, raster_done;
    logic [15:0]       px, py, pcolor;
    logic [1:0]        pdepth;
    logic [ADDR_W-1:0] zb_addr, fb_addr;
    logic [1:0]        zb_wdata, zb_rdata;
    logic              zb_we, fb_we, fb_ready;
    logic [15:0]       fb_data;
    logic              fifo_full, busy, overflow, frame_done;
    logic [19:0]       written, rejected;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    raster_pixel_writer #(
        .SCREEN_W(8), .SCREEN_H(4), .FIFO_DEPTH(4), .ADDR_W(ADDR_W)
    ) dut (
        .clock                    (clock),
        .reset_n                  (reset_n),
        .in_sig_start_new_triangle(start_tri),
        .in_sig_clear_depth       (clear_depth),
        .in_sig_write_pixel       (write_pixel),
        .in_sig_rasterize_done    (raster_done),
        .in_pixel_x               (px),
        .in_pixel_y               (py),
        .in_pixel_depth           (pdepth),
        .in_pixel_color           (pcolor),
        .out_zb_addr              (zb_addr),
        .out_zb_wdata             (zb_wdata),
        .out_zb_we                (zb_we),
        .in_zb_rdata              (zb_rdata),
        .out_fb_addr              (fb_addr),
        .out_fb_data              (fb_data),
        .out_fb_we                (fb_we),
        .in_fb_ready              (fb_ready),
        .out_sig_fifo_full        (fifo_full),
        .out_sig_busy             (busy),
        .out_sig_overflow         (overflow),
        .out_sig_frame_done       (frame_done),
        .out_pixels_written       (written),
        .out_pixels_rejected      (rejected)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic [15:0] y,
                        input logic [1:0] d, input logic [15:0] c);
        write_pixel = 1'b1;
        px = x; py = y; pdepth = d; pcolor = c;
        tick();
        write_pixel = 1'b0;
    endtask

    initial begin
        logic found, seen_zb, seen_fb, bad_access;
        int   n_done, done_cyc, last_wr;

        reset_n = 1'b0; start_tri = 1'b0; clear_depth = 1'b0; write_pixel = 1'b0;
        raster_done = 1'b0; px = '0; py = '0; pdepth = '0; pcolor = '0;
        zb_rdata = 2'd3; fb_ready = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        check_eq("rst_zb_we", zb_we, 0);
        check_eq("rst_fb_we", fb_we, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_full", fifo_full, 0);
        check_eq("rst_flags", {overflow, frame_done}, 0);
        check_eq("rst_counts", {written, rejected}, 0);
        check_eq("rst_addr", {zb_addr, fb_addr, fb_data}, 0);
        reset_n = 1'b1;
        tick();

        // ---- depth-buffer clear: 32 words of 3 ----
        clear_depth = 1'b1;
        tick();
        clear_depth = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            @(negedge clock);
            if (zb_we) found = 1'b1;
            else tick();
        end
        check_eq("clear_start", found, 1);
        for (int i = 0; i < 32; i++) begin
            logic [ADDR_W-1:0] ea;
            ea = ADDR_W'(i);
            check_eq("clear_word", {zb_we, zb_wdata, zb_addr}, {1'b1, 2'b11, ea});
            tick();
            @(negedge clock);
        end
        check_eq("clear_end_we", zb_we, 0);
        check_eq("clear_end_busy", busy, 0);
        tick();

        // ---- single passing pixel, latency ----
        zb_rdata = 2'd3; fb_ready = 1'b1;
        send(16'd3, 16'd2, 2'd1, 16'hF00F);
        @(negedge clock);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_we", {zb_we, fb_we}, 0);
        tick(); @(negedge clock);
        check_eq("t2_readz", {zb_we, fb_we, zb_addr}, {2'b00, 19'd19});
        tick(); @(negedge clock);
        check_eq("t3_zbw", {zb_we, zb_wdata, zb_addr, fb_we}, {1'b1, 2'd1, 19'd19, 1'b0});
        tick(); @(negedge clock);
        check_eq("t4_fbw", {fb_we, fb_addr, fb_data}, {1'b1, 19'd19, 16'hF00F});
        tick(); @(negedge clock);
        check_eq("t5_written", written, 1);
        check_eq("t5_idle", {fb_we, busy}, 0);
        tick();

        // ---- depth reject, then equal-depth pass ----
        zb_rdata = 2'd0;
        send(16'd3, 16'd2, 2'd1, 16'hF00F);
        seen_zb = 1'b0; seen_fb = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            seen_zb |= zb_we; seen_fb |= fb_we;
            tick();
        end
        check_eq("rej_no_mem", {seen_zb, seen_fb}, 0);
        check_eq("rej_count", rejected, 1);
        check_eq("rej_written", written, 1);
        zb_rdata = 2'd1;
        send(16'd3, 16'd2, 2'd1, 16'hF00F);
        repeat (6) tick();
        @(negedge clock);
        check_eq("eq_written", written, 2);
        check_eq("eq_rejected", rejected, 1);
        tick();

        // ---- FIFO fill with fb stalled, one drop ----
        zb_rdata = 2'd3; fb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            write_pixel = 1'b1;
            px = 16'(i); py = 16'd0; pdepth = 2'd0; pcolor = 16'(i);
            @(negedge clock);
            if (i == 4) check_eq("fill_not_full", fifo_full, 0);
            if (i == 5) check_eq("fill_full", fifo_full, 1);
            tick();
        end
        write_pixel = 1'b0;
        @(negedge clock);
        check_eq("fill_overflow", overflow, 1);
        tick();
        fb_ready = 1'b1;
        repeat (30) tick();
        @(negedge clock);
        check_eq("fill_written", written, 7);
        check_eq("fill_drain", {busy, fifo_full}, 0);
        check_eq("fill_ovf_sticky", overflow, 1);
        tick();
        start_tri = 1'b1;
        tick();
        start_tri = 1'b0;
        @(negedge clock);
        check_eq("start_clears_ovf", overflow, 0);
        tick();

        // ---- fb_ready low for 5 cycles in WRITE_FB ----
        fb_ready = 1'b0;
        send(16'd5, 16'd1, 2'd0, 16'h1234);
        repeat (3) tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_eq("stall_hold", {fb_we, fb_addr, fb_data}, {1'b1, 19'd13, 16'h1234});
            tick();
        end
        fb_ready = 1'b1;
        @(negedge clock);
        check_eq("stall_wr_before", written, 7);
        tick(); @(negedge clock);
        check_eq("stall_written", written, 8);
        repeat (3) tick();
        @(negedge clock);
        check_eq("stall_once", {written, fb_we}, {20'd8, 1'b0});
        tick();

        // ---- frame done after queued pixels plus off-screen strobe ----
        zb_rdata = 2'd3; fb_ready = 1'b1;
        send(16'd1, 16'd0, 2'd0, 16'hAAAA);
        send(16'd2, 16'd3, 2'd0, 16'hBBBB);
        raster_done = 1'b1;
        send(16'd8, 16'd1, 2'd0, 16'hCCCC);
        n_done = 0; done_cyc = -10; last_wr = -20; bad_access = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (fb_we && fb_ready) last_wr = cyc;
            if (frame_done) begin n_done++; done_cyc = cyc; end
            if (zb_we && zb_addr != 19'd1 && zb_addr != 19'd26) bad_access = 1'b1;
            tick();
        end
        check_eq("fd_pulses", n_done, 1);
        check_eq("fd_timing", done_cyc, last_wr + 1);
        check_eq("fd_no_bad_access", bad_access, 0);
        check_eq("fd_rejected", rejected, 2);
        check_eq("fd_written", written, 10);

        // ---- reset mid-operation ----
        send(16'd0, 16'd1, 2'd0, 16'h5555);
        tick();
        reset_n = 1'b0;
        tick();
        @(negedge clock);
        check_eq("midrst_idle", {busy, zb_we, fb_we, fifo_full}, 0);
        check_eq("midrst_counts", {written, rejected}, 0);
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/raster_pixel_writer.md
Name: raster_pixel_writer

Overview:
- Consumes the pixel stream produced by the edge rasterizer: the write-pixel strobe plus pixel x, y, depth and color.
- Buffers pixels in a small FIFO and performs a 2-bit depth test against an external depth buffer.
- Writes passing pixels to an external framebuffer port.
- Also clears the depth buffer on request and reports frame completion back to the sequencing logic.

Parameters:
SCREEN_W, 640, pixels per row; row stride of the address computation
SCREEN_H, 480, number of rows
FIFO_DEPTH, 4, pixel FIFO entries (power of 2, minimum 2)
ADDR_W, 19, depth-buffer and framebuffer address width

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
in_sig_start_new_triangle  in  1  level; clears done_seen and overflow flags
in_sig_clear_depth  in  1  pulse; requests depth-buffer clear
in_sig_write_pixel  in  1  pixel strobe; one pixel per high cycle
in_sig_rasterize_done  in  1  level from rasterizer; rising edge marks end of triangle
in_pixel_x  in  16  pixel x
in_pixel_y  in  16  pixel y
in_pixel_depth  in  2  pixel depth, 0 = nearest
in_pixel_color  in  16  ARGB4444 color
out_zb_addr  out  ADDR_W  depth-buffer address
out_zb_wdata  out  2  depth-buffer write data
out_zb_we  out  1  depth-buffer write enable, one cycle per write
in_zb_rdata  in  2  depth-buffer read data, valid one cycle after out_zb_addr is presented
out_fb_addr  out  ADDR_W  framebuffer address
out_fb_data  out  16  framebuffer write data
out_fb_we  out  1  framebuffer write request
in_fb_ready  in  1  framebuffer accepts write when out_fb_we & in_fb_ready
out_sig_fifo_full  out  1  FIFO full; upstream must pause rasterize phase
out_sig_busy  out  1  FSM not IDLE or FIFO non-empty
out_sig_overflow  out  1  sticky; a strobe was dropped
out_sig_frame_done  out  1  one-cycle pulse
out_pixels_written  out  20  framebuffer writes completed
out_pixels_rejected  out  20  pixels failing depth test or off-screen

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, flags and counters 0.
- Enqueue:
  - A strobe with x>=SCREEN_W or y>=SCREEN_H is not enqueued; rejected counter +1.
  - Otherwise push {addr = y*SCREEN_W + x (truncated to ADDR_W), depth, color}.
  - Strobe while full with no pop that cycle: pixel dropped, out_sig_overflow set.
  - Push and pop in the same cycle are both honoured, including when full.
- FSM states: IDLE, READ_Z, TEST, WRITE_FB, CLEAR.
  - IDLE:
    - If a clear is pending and the FIFO is empty, go to CLEAR.
    - Else if the FIFO is non-empty, pop the head into working registers and go to READ_Z.
    - A clear request arriving while pixels are queued is latched and waits for the FIFO to drain.
  - READ_Z: out_zb_addr = working addr; go to TEST.
  - TEST:
    - Sample in_zb_rdata.
    - If depth <= rdata: out_zb_we=1, out_zb_wdata=depth, out_zb_addr=addr; go to WRITE_FB.
    - Else: rejected +1; go to IDLE.
  - WRITE_FB:
    - out_fb_we=1, with out_fb_addr and out_fb_data held stable.
    - When in_fb_ready is high: written +1; go to IDLE next cycle.
  - CLEAR:
    - Write 2'b11 to addresses 0..SCREEN_W*SCREEN_H-1, one per cycle with out_zb_we=1, then go to IDLE.
    - Entry to CLEAR zeroes both counters.
    - Strobes arriving during CLEAR are still enqueued.
- Latency and throughput:
  - Strobe sampled at cycle t: pop at t+1, READ_Z at t+2, zb write at t+3, fb_we at t+4.
  - Peak rate is 1 pixel per 4 cycles with fb_ready high.
- Frame done:
  - A rising edge of in_sig_rasterize_done sets done_seen.
  - When done_seen is set, state is IDLE, the FIFO is empty and no clear is pending: pulse out_sig_frame_done for one cycle and clear done_seen.
  - in_sig_start_new_triangle clears done_seen and overflow; it has no effect on queued pixels.
- Counters saturate at 2^20-1.
- Reset mid-operation: FIFO flushed, any in-flight write abandoned, all outputs return to reset values on the next edge.

Test Plan:
- SCREEN_W=8, SCREEN_H=4; reset, then pulse clear -> 32 consecutive cycles with out_zb_we=1, addr 0..31, wdata 3; then out_sig_busy=0.
- Strobe x=3 y=2 depth=1 color F00F, zb_rdata=3, fb_ready=1 -> out_zb_we at t+3 with addr 19, wdata 1; out_fb_we at t+4 with addr 19, data F00F; written=1.
- Same pixel with zb_rdata=0 -> no zb_we, no fb_we, rejected=1; then zb_rdata=1 -> pixel passes (equal depth accepted).
- FIFO_DEPTH=4, fb_ready=0, 6 back-to-back strobes -> fifo_full asserts; exactly 1 strobe dropped and overflow=1; release ready -> written=5; start_new_triangle clears overflow.
- fb_ready low for 5 cycles during WRITE_FB -> fb_we, addr and data stable all 5 cycles; written increments once.
- rasterize_done rises with 2 pixels queued, plus an off-screen strobe x=8 -> rejected +1 with no memory access; frame_done pulses once, one cycle after the final write completes.
